// File: rtl/plru_way_select_pkg.sv
// Shared constants, types and one-hot helpers for the tree pseudo-LRU way selector.
// Widths in this package set the geometry that every plru_way_select instance must use.
package plru_way_select_pkg;

   localparam int unsigned PLRU_NUM_WAY      = 8;
   localparam int unsigned PLRU_NUM_SET      = 16;
   localparam int unsigned NUM_WAY_LOG2      = $clog2(PLRU_NUM_WAY);
   localparam int unsigned SET_INDEX_WIDTH   = $clog2(PLRU_NUM_SET);
   localparam int unsigned PLRU_BITS_PER_SET = PLRU_NUM_WAY - 1;

   typedef logic [PLRU_NUM_WAY-1:0]      way_vec_t;
   typedef logic [NUM_WAY_LOG2-1:0]      way_idx_t;
   typedef logic [SET_INDEX_WIDTH-1:0]   set_idx_t;
   typedef logic [PLRU_BITS_PER_SET-1:0] plru_bits_t;

   function automatic logic is_onehot(way_vec_t v);
      return (v != '0) && ((v & (v - way_vec_t'(1))) == '0);
   endfunction

   function automatic way_idx_t onehot_to_bin(way_vec_t v);
      way_idx_t b = '0;
      for (int i = 0; i < PLRU_NUM_WAY; i++) begin
         if (v[i]) b |= way_idx_t'(i);
      end
      return b;
   endfunction

   function automatic way_vec_t bin_to_onehot(way_idx_t b);
      way_vec_t v = '0;
      v[b] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/plru_way_select_if.sv
// Access/query/victim bundle between the cache controller and the PLRU way selector.
interface plru_way_select_if;
   import plru_way_select_pkg::*;

   logic     access_valid_in;
   set_idx_t access_set_in;
   way_vec_t access_way_in;
   logic     query_valid_in;
   set_idx_t query_set_in;
   way_vec_t way_valid_in;
   logic     victim_valid_out;
   way_vec_t victim_way_out;
   logic     access_error_out;

   modport master (
      output access_valid_in, access_set_in, access_way_in,
      output query_valid_in, query_set_in, way_valid_in,
      input  victim_valid_out, victim_way_out, access_error_out
   );

   modport slave (
      input  access_valid_in, access_set_in, access_way_in,
      input  query_valid_in, query_set_in, way_valid_in,
      output victim_valid_out, victim_way_out, access_error_out
   );

endinterface

// File: rtl/plru_tree_update.sv
// Combinational next-state for one set's PLRU tree: every node on the path to the
// accessed way is turned to point away from it (left turn writes 1, right turn writes 0).
module plru_tree_update
   import plru_way_select_pkg::*;
(
   input  plru_bits_t plru_i,
   input  way_idx_t   way_idx_i,
   output plru_bits_t plru_o
);

   way_idx_t node;
   logic     dir;

   always_comb begin
      plru_o = plru_i;
      node   = '0;
      dir    = 1'b0;
      for (int lvl = 0; lvl < NUM_WAY_LOG2; lvl++) begin
         // Way index bits, MSB first, give the left/right turn at each level.
         dir          = way_idx_i[NUM_WAY_LOG2-1-lvl];
         plru_o[node] = ~dir;
         node         = (node << 1) + way_idx_t'(1) + way_idx_t'(dir);
      end
   end

endmodule

// File: rtl/plru_way_select.sv
// Tree pseudo-LRU victim selector: per-set PLRU state, update on legal accesses,
// registered one-hot victim (invalid ways first) one cycle after each query.
module plru_way_select
   import plru_way_select_pkg::*;
#(
   parameter int unsigned NUM_WAY = PLRU_NUM_WAY,
   parameter int unsigned NUM_SET = PLRU_NUM_SET
) (
   input logic              clk_in,
   input logic              reset_in,
   plru_way_select_if.slave bus_if
);

   plru_bits_t         plru_q [NUM_SET];
   plru_bits_t         plru_rd;
   plru_bits_t         plru_upd;
   way_idx_t           acc_idx;
   logic               acc_legal;
   way_idx_t           walk_idx;
   way_idx_t           node;
   logic [NUM_WAY-1:0] inv_oh;
   logic               inv_found;
   logic [NUM_WAY-1:0] victim_way_d;

   logic               victim_valid_q;
   logic [NUM_WAY-1:0] victim_way_q;
   logic               access_error_q;

   assign acc_legal = is_onehot(bus_if.access_way_in);
   assign acc_idx   = onehot_to_bin(bus_if.access_way_in);
   // Query reads the registered state, so a same-cycle access to the same set is not seen yet.
   assign plru_rd   = plru_q[bus_if.query_set_in];

   plru_tree_update u_tree_update (
      .plru_i    (plru_q[bus_if.access_set_in]),
      .way_idx_i (acc_idx),
      .plru_o    (plru_upd)
   );

   always_comb begin
      node     = '0;
      walk_idx = '0;
      for (int lvl = 0; lvl < NUM_WAY_LOG2; lvl++) begin
         walk_idx[NUM_WAY_LOG2-1-lvl] = plru_rd[node];
         node = (node << 1) + way_idx_t'(1) + way_idx_t'(plru_rd[node]);
      end
   end

   always_comb begin
      inv_oh    = '0;
      inv_found = 1'b0;
      for (int w = 0; w < NUM_WAY; w++) begin
         if (!inv_found && !bus_if.way_valid_in[w]) begin
            inv_oh[w] = 1'b1;
            inv_found = 1'b1;
         end
      end
      victim_way_d = inv_found ? inv_oh : bin_to_onehot(walk_idx);
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         for (int s = 0; s < NUM_SET; s++) begin
            plru_q[s] <= '0;
         end
         victim_valid_q <= 1'b0;
         victim_way_q   <= '0;
         access_error_q <= 1'b0;
      end else begin
         if (bus_if.access_valid_in && acc_legal) begin
            plru_q[bus_if.access_set_in] <= plru_upd;
         end
         victim_valid_q <= bus_if.query_valid_in;
         victim_way_q   <= bus_if.query_valid_in ? victim_way_d : '0;
         access_error_q <= bus_if.access_valid_in && !acc_legal;
      end
   end

   assign bus_if.victim_valid_out = victim_valid_q;
   assign bus_if.victim_way_out   = victim_way_q;
   assign bus_if.access_error_out = access_error_q;

endmodule

// File: tb/tb_plru_way_select.sv
// Bench for plru_way_select: directed cases plus random traffic against a recency-based
// reference (each tree level picks the half not holding the most recent access).
module tb_plru_way_select;
   import plru_way_select_pkg::*;

   localparam int NW = PLRU_NUM_WAY;
   localparam int NS = PLRU_NUM_SET;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   plru_way_select_if bus ();

   plru_way_select #(
      .NUM_WAY (NW),
      .NUM_SET (NS)
   ) dut (
      .clk_in   (clk),
      .reset_in (rst),
      .bus_if   (bus)
   );

   int checks = 0;
   int errors = 0;

   int unsigned stamp [NS][NW];
   int unsigned now_t;
   logic          exp_vv;
   logic          exp_err;
   logic [NW-1:0] exp_way;

   function automatic int ref_victim(int set, logic [NW-1:0] valid);
      int lo;
      int size;
      int half;
      int unsigned ml;
      int unsigned mr;
      for (int w = 0; w < NW; w++) begin
         if (!valid[w]) return w;
      end
      lo   = 0;
      size = NW;
      while (size > 1) begin
         half = size / 2;
         ml   = 0;
         mr   = 0;
         for (int w = lo; w < lo + half; w++) if (stamp[set][w] > ml) ml = stamp[set][w];
         for (int w = lo + half; w < lo + size; w++) if (stamp[set][w] > mr) mr = stamp[set][w];
         if (ml > mr) lo += half;
         size = half;
      end
      return lo;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) stamp[s][w] = 0;
      now_t = 0;
   endtask

   task automatic set_idle();
      bus.access_valid_in = 1'b0;
      bus.access_set_in   = '0;
      bus.access_way_in   = '0;
      bus.query_valid_in  = 1'b0;
      bus.query_set_in    = '0;
      bus.way_valid_in    = '1;
   endtask

   // Applies one cycle of stimulus, predicts the outputs seen at the following negedge.
   task automatic drive(input logic av, input int aset, input logic [NW-1:0] away,
                        input logic qv, input int qset, input logic [NW-1:0] wv);
      logic [NW-1:0] one;
      one = 1;
      bus.access_valid_in = av;
      bus.access_set_in   = set_idx_t'(aset);
      bus.access_way_in   = away;
      bus.query_valid_in  = qv;
      bus.query_set_in    = set_idx_t'(qset);
      bus.way_valid_in    = wv;
      exp_vv  = qv;
      exp_way = qv ? (one << ref_victim(qset, wv)) : '0;
      exp_err = av && ($countones(away) != 1);
      if (av && $countones(away) == 1) begin
         now_t++;
         for (int w = 0; w < NW; w++) if (away[w]) stamp[aset][w] = now_t;
      end
      @(negedge clk);
      set_idle();
   endtask

   // Reset asserted together with a query and an access; both must be dropped.
   task automatic do_reset();
      rst = 1'b1;
      bus.access_valid_in = 1'b1;
      bus.access_set_in   = '0;
      bus.access_way_in   = 8'h01;
      bus.query_valid_in  = 1'b1;
      bus.query_set_in    = '0;
      bus.way_valid_in    = 8'hFF;
      @(negedge clk);
      rst = 1'b0;
      set_idle();
      model_clear();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.victim_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_vv: got %b expected 0", bus.victim_valid_out);
      end
      checks++;
      if (bus.victim_way_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_way: got %h expected 00", bus.victim_way_out);
      end
      checks++;
      if (bus.access_error_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: got %b expected 0", bus.access_error_out);
      end
      drive(1'b0, 0, 8'h00, 1'b0, 0, 8'hFF);
      checks++;
      if (bus.victim_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_pulse: got %b expected 0", bus.victim_valid_out);
      end
      drive(1'b0, 0, 8'h00, 1'b1, 0, 8'hFF);
      checks++;
      if (bus.victim_valid_out !== 1'b1 || bus.victim_way_out !== 8'h01) begin
         errors++;
         $display("FAIL reset_query: got vv=%b way=%h expected vv=1 way=01",
                  bus.victim_valid_out, bus.victim_way_out);
      end
   endtask

   task automatic test_access_update();
      do_reset();
      drive(1'b1, 0, 8'h01, 1'b0, 0, 8'hFF);
      drive(1'b0, 0, 8'h00, 1'b1, 0, 8'hFF);
      checks++;
      if (bus.victim_way_out !== 8'h10) begin
         errors++;
         $display("FAIL access_set0: got %h expected 10", bus.victim_way_out);
      end
      drive(1'b1, 2, 8'h01, 1'b0, 0, 8'hFF);
      drive(1'b1, 2, 8'h10, 1'b0, 0, 8'hFF);
      drive(1'b1, 2, 8'h04, 1'b0, 0, 8'hFF);
      drive(1'b1, 2, 8'h40, 1'b0, 0, 8'hFF);
      drive(1'b0, 0, 8'h00, 1'b1, 2, 8'hFF);
      checks++;
      if (bus.victim_way_out !== 8'h02) begin
         errors++;
         $display("FAIL access_set2_seq: got %h expected 02", bus.victim_way_out);
      end
   endtask

   task automatic test_invalid_first();
      drive(1'b1, 5, 8'h01, 1'b1, 5, 8'b1101_1111);
      checks++;
      if (bus.victim_way_out !== 8'h20) begin
         errors++;
         $display("FAIL invalid_first: got %h expected 20", bus.victim_way_out);
      end
      drive(1'b1, 5, 8'h20, 1'b1, 5, 8'b1101_1111);
      checks++;
      if (bus.victim_way_out !== 8'h20) begin
         errors++;
         $display("FAIL invalid_first_after_access: got %h expected 20", bus.victim_way_out);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      drive(1'b1, 0, 8'h01, 1'b1, 0, 8'hFF);
      checks++;
      if (bus.victim_way_out !== 8'h01) begin
         errors++;
         $display("FAIL same_cycle_rbw: got %h expected 01", bus.victim_way_out);
      end
      drive(1'b0, 0, 8'h00, 1'b1, 0, 8'hFF);
      checks++;
      if (bus.victim_way_out !== 8'h10) begin
         errors++;
         $display("FAIL same_cycle_commit: got %h expected 10", bus.victim_way_out);
      end
      drive(1'b0, 0, 8'h00, 1'b0, 0, 8'hFF);
      checks++;
      if (bus.victim_valid_out !== 1'b0 || bus.victim_way_out !== 8'h00) begin
         errors++;
         $display("FAIL idle_zero: got vv=%b way=%h expected vv=0 way=00",
                  bus.victim_valid_out, bus.victim_way_out);
      end
   endtask

   task automatic test_illegal_and_sets();
      do_reset();
      drive(1'b1, 3, 8'h03, 1'b0, 0, 8'hFF);
      checks++;
      if (bus.access_error_out !== 1'b1) begin
         errors++;
         $display("FAIL illegal_err: got %b expected 1", bus.access_error_out);
      end
      drive(1'b0, 0, 8'h00, 1'b1, 3, 8'hFF);
      checks++;
      if (bus.access_error_out !== 1'b0 || bus.victim_way_out !== 8'h01) begin
         errors++;
         $display("FAIL illegal_no_update: got err=%b way=%h expected err=0 way=01",
                  bus.access_error_out, bus.victim_way_out);
      end
      drive(1'b1, 3, 8'h00, 1'b0, 0, 8'hFF);
      checks++;
      if (bus.access_error_out !== 1'b1) begin
         errors++;
         $display("FAIL zero_way_err: got %b expected 1", bus.access_error_out);
      end
      drive(1'b1, 3, 8'h01, 1'b0, 0, 8'hFF);
      drive(1'b0, 0, 8'h00, 1'b1, 4, 8'hFF);
      checks++;
      if (bus.victim_way_out !== 8'h01) begin
         errors++;
         $display("FAIL other_set_untouched: got %h expected 01", bus.victim_way_out);
      end
      drive(1'b0, 0, 8'h00, 1'b1, 3, 8'hFF);
      checks++;
      if (bus.victim_way_out !== 8'h10) begin
         errors++;
         $display("FAIL set3_updated: got %h expected 10", bus.victim_way_out);
      end
   endtask

   task automatic test_random();
      logic          av;
      logic          qv;
      int            aset;
      int            qset;
      logic [NW-1:0] away;
      logic [NW-1:0] wv;
      logic [NW-1:0] one;
      one = 1;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         av   = ($urandom_range(0, 3) != 0);
         qv   = ($urandom_range(0, 3) != 0);
         aset = $urandom_range(0, 3);
         qset = $urandom_range(0, 3);
         away = ($urandom_range(0, 7) == 0) ? NW'($urandom) : (one << $urandom_range(0, NW - 1));
         wv   = ($urandom_range(0, 3) == 0) ? NW'($urandom) : 8'hFF;
         drive(av, aset, away, qv, qset, wv);
         checks++;
         if (bus.victim_valid_out !== exp_vv || bus.victim_way_out !== exp_way) begin
            errors++;
            $display("FAIL random_victim[%0d]: got vv=%b way=%h expected vv=%b way=%h",
                     i, bus.victim_valid_out, bus.victim_way_out, exp_vv, exp_way);
         end
         checks++;
         if (bus.access_error_out !== exp_err) begin
            errors++;
            $display("FAIL random_err[%0d]: got %b expected %b", i, bus.access_error_out, exp_err);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      model_clear();
      test_reset();
      test_access_update();
      test_invalid_first();
      test_same_cycle();
      test_illegal_and_sets();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/plru_way_select.md
Name: plru_way_select

Overview:
- Tree pseudo-LRU replacement unit for the set-associative cache.
- Keeps NUM_WAY-1 PLRU bits per set and updates them on every tag-hit or fill access.
- On a query, produces a registered one-hot victim-way vector.
- That vector drives the decoded-select input (sel_in) of the downstream one-hot way mux, which picks the victim's tag/data for writeback/refill.

Parameters:
NUM_WAY, 8, ways per set; power of two, >= 2
NUM_SET, 16, number of sets; power of two, >= 2
SET_INDEX_WIDTH, $clog2(NUM_SET), localparam derived, not overridable

Ports:
clk_in  input  1  clock; all state updates on rising edge
reset_in  input  1  synchronous, active-high reset
access_valid_in  input  1  access (hit or fill) this cycle
access_set_in  input  SET_INDEX_WIDTH  set of the access
access_way_in  input  NUM_WAY  one-hot way accessed
query_valid_in  input  1  victim request this cycle
query_set_in  input  SET_INDEX_WIDTH  set being queried
way_valid_in  input  NUM_WAY  per-way valid bits of the queried set (same cycle as query)
victim_valid_out  output  1  victim_way_out is valid this cycle
victim_way_out  output  NUM_WAY  one-hot victim way; feeds sel_in of the way mux
access_error_out  output  1  one-cycle pulse: access_way_in was not one-hot

Behaviour:
- Interface: one clock, clk_in; reset_in is synchronous and active-high.
- Reset: all PLRU bits of all sets = 0. victim_valid_out = 0, victim_way_out = 0, access_error_out = 0 on the cycle after reset_in is sampled high.
- Reset mid-operation: a query or access in flight is dropped. No victim_valid_out pulse follows a query sampled together with reset_in.
- Tree layout:
  - Heap indexing: root is node 0; node i has children 2i+1 and 2i+2.
  - Leaves map to ways 0..NUM_WAY-1 left to right.
  - Node bit 0 = victim lies in the left (lower-index) subtree; bit 1 = right.
- Access update:
  - Applies when access_valid_in=1 and access_way_in is one-hot.
  - Every node on the path to the accessed way is set to point away from it. Going left writes 1; going right writes 0.
  - Nodes off the path are unchanged.
  - The new state is visible to queries from the next cycle.
- Illegal access: if access_way_in is zero or has more than one bit set, state is unchanged and access_error_out=1 in the next cycle.
- Query, latency 1 cycle: when query_valid_in=1 in cycle N, victim_valid_out=1 and victim_way_out holds the result in cycle N+1.
  - Invalid ways first: if any way_valid_in bit is 0, the victim is the lowest-index invalid way.
  - Otherwise: walk the tree from the root following the node bits.
  - The query itself does not modify PLRU state.
- No query: victim_valid_out=0 and victim_way_out=0 whenever no query was sampled in the previous cycle. The output is always exactly one-hot or all-zero.
- Same set, same cycle: if a query and an access target the same set, the query uses the pre-update state (read-before-write). The access update still commits.
- Back-to-back: queries may be issued every cycle, and accesses every cycle. There is no backpressure.
- Different sets: an access to set A never changes the PLRU bits of set B.

Decomposition:
- Shared package holds:
  - localparams NUM_WAY_LOG2 and SET_INDEX_WIDTH;
  - constant PLRU_BITS_PER_SET = NUM_WAY-1;
  - a one-hot-check function;
  - the one-hot-to-binary and binary-to-one-hot functions used by the victim walk and the update path.
- One sub-module, plru_tree_update. It is purely combinational: it takes the current per-set PLRU bits and the accessed way index, and returns the next PLRU bits.
- The top level holds the per-set state flops, the victim walk, the invalid-way priority logic and the output registers.

Test Plan:
- Reset, then query set 0 with way_valid_in=8'hFF -> next cycle victim_valid_out=1, victim_way_out=8'b0000_0001.
- Access set 0 with way 8'b0000_0001, then query set 0 (all valid) -> victim_way_out=8'b0001_0000.
- Access set 2 with ways 0, 4, 2, 6 in consecutive cycles, then query set 2 (all valid) -> victim_way_out=8'b0000_0010.
- Query set 5 with way_valid_in=8'b1101_1111 -> victim_way_out=8'b0010_0000, regardless of PLRU state.
- Access and query set 0 in the same cycle, both fresh after reset, all valid -> victim_way_out=8'b0000_0001. A further query in the next cycle -> 8'b0001_0000.
- Access set 3 with access_way_in=8'b0000_0011 -> access_error_out pulses one cycle; a query on set 3 -> 8'b0000_0001. An access to set 3 way 0 followed by a query on set 4 -> 8'b0000_0001.
